// File: rtl/fft_frame_sched_if.sv
// Handshake/bus bundle between fft_frame_sched and its writer / FFT engine.
//   master : environment side (drives enable, wr_beat, fft_done)
//   slave  : scheduler side (drives wr_allow, wr_addr, fft_start, fft_bank, fft_base,
//            overflow, done_err and, with FFT_SCHED_STATS_EN, frame_cnt/stall_cnt)
// Optional feature macro: FFT_SCHED_STATS_EN adds the statistics counters.
interface fft_frame_sched_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              enable;
  logic              wr_beat;
  logic              wr_allow;
  logic [ADDR_W-1:0] wr_addr;
  logic              fft_done;
  logic              fft_start;
  logic              fft_bank;
  logic [ADDR_W-1:0] fft_base;
  logic              overflow;
  logic              done_err;
`ifdef FFT_SCHED_STATS_EN
  logic [15:0]       frame_cnt;
  logic [15:0]       stall_cnt;

  modport master (
    output enable, wr_beat, fft_done,
    input  wr_allow, wr_addr, fft_start, fft_bank, fft_base, overflow, done_err,
    input  frame_cnt, stall_cnt
  );
  modport slave (
    input  enable, wr_beat, fft_done,
    output wr_allow, wr_addr, fft_start, fft_bank, fft_base, overflow, done_err,
    output frame_cnt, stall_cnt
  );
`else
  modport master (
    output enable, wr_beat, fft_done,
    input  wr_allow, wr_addr, fft_start, fft_bank, fft_base, overflow, done_err
  );
  modport slave (
    input  enable, wr_beat, fft_done,
    output wr_allow, wr_addr, fft_start, fft_bank, fft_base, overflow, done_err
  );
`endif
endinterface

// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler between the ADC->BRAM writer and the FFT read engine.
// The BRAM is split into two banks of FRAME_SAMPLES words; each bank cycles
// FREE -> FILLING -> FULL -> BUSY -> FREE. Full banks are handed to the engine in
// strict alternating order, and the writer is back-pressured when its bank is taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fft_frame_sched_if.slave (enable, wr_beat, fft_done in;
//                wr_allow, wr_addr, fft_start, fft_bank, fft_base, overflow, done_err out)
// Optional feature macro: FFT_SCHED_STATS_EN adds saturating frame_cnt / stall_cnt.
module fft_frame_sched #(
  parameter int unsigned FRAME_SAMPLES = 1024,
  parameter int unsigned ADDR_W        = 13,
  parameter int unsigned ADDR_STEP     = 4
) (
  input logic              clk,
  input logic              rst_n,
  fft_frame_sched_if.slave bus
);
  localparam int unsigned       IdxW      = $clog2(FRAME_SAMPLES);
  localparam logic [ADDR_W-1:0] BankBytes = ADDR_W'(FRAME_SAMPLES * ADDR_STEP);
  localparam logic [ADDR_W-1:0] StepBytes = ADDR_W'(ADDR_STEP);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(FRAME_SAMPLES - 1);
  localparam logic [IdxW-1:0]   IdxOne    = IdxW'(1);

  typedef enum logic [1:0] {BankFree, BankFilling, BankFull, BankBusy} bank_st_e;

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            wr_allow_q, wr_allow_d;
  logic            eng_busy_q, eng_busy_d;
  logic            next_bank_q, next_bank_d;  // bank owed the next fft_start
  logic            fft_start_q, fft_start_d;
  logic            fft_bank_q, fft_bank_d;
  logic            overflow_q, overflow_d;
  logic            done_err_q, done_err_d;
  logic            accept;

  assign accept = bus.wr_beat & wr_allow_q;

  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    idx_d       = idx_q;
    eng_busy_d  = eng_busy_q;
    next_bank_d = next_bank_q;
    fft_start_d = 1'b0;
    fft_bank_d  = fft_bank_q;
    overflow_d  = overflow_q;
    done_err_d  = done_err_q;

    if (bus.wr_beat && !wr_allow_q) begin
      overflow_d = 1'b1;
    end

    // Completion is applied before the write side so a freed bank is
    // immediately visible to a writer that finishes its frame this cycle.
    if (bus.fft_done) begin
      if (eng_busy_q) begin
        bank_d[fft_bank_q] = BankFree;
        eng_busy_d         = 1'b0;
      end else begin
        done_err_d = 1'b1;
      end
    end

    if (accept) begin
      if (idx_q == IdxLast) begin
        bank_d[wr_bank_q] = BankFull;
        idx_d             = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        bank_d[wr_bank_q] = BankFilling;
        idx_d             = idx_q + IdxOne;
      end
    end

    // Start decision sees this cycle's done and final beat, giving 1-cycle latency.
    if (!eng_busy_d && bus.enable && bank_d[next_bank_q] == BankFull) begin
      bank_d[next_bank_q] = BankBusy;
      eng_busy_d          = 1'b1;
      fft_start_d         = 1'b1;
      fft_bank_d          = next_bank_q;
      next_bank_d         = ~next_bank_q;
    end

    wr_allow_d = bus.enable &
                 ((bank_d[wr_bank_d] == BankFree) || (bank_d[wr_bank_d] == BankFilling));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]   <= BankFree;
      bank_q[1]   <= BankFree;
      wr_bank_q   <= 1'b0;
      idx_q       <= '0;
      wr_allow_q  <= 1'b0;
      eng_busy_q  <= 1'b0;
      next_bank_q <= 1'b0;
      fft_start_q <= 1'b0;
      fft_bank_q  <= 1'b0;
      overflow_q  <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      idx_q       <= idx_d;
      wr_allow_q  <= wr_allow_d;
      eng_busy_q  <= eng_busy_d;
      next_bank_q <= next_bank_d;
      fft_start_q <= fft_start_d;
      fft_bank_q  <= fft_bank_d;
      overflow_q  <= overflow_d;
      done_err_q  <= done_err_d;
    end
  end

  assign bus.wr_allow  = wr_allow_q;
  assign bus.wr_addr   = (wr_bank_q ? BankBytes : '0) + ADDR_W'(idx_q) * StepBytes;
  assign bus.fft_start = fft_start_q;
  assign bus.fft_bank  = fft_bank_q;
  assign bus.fft_base  = fft_bank_q ? BankBytes : '0;
  assign bus.overflow  = overflow_q;
  assign bus.done_err  = done_err_q;

`ifdef FFT_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fft_start_d && frame_cnt_q != 16'hFFFF) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (bus.enable && !wr_allow_q && stall_cnt_q != 16'hFFFF) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
`timescale 1ns/1ps
module tb_fft_frame_sched;
  localparam int unsigned FRAME      = 1024;
  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned STEP       = 4;
  localparam int unsigned BANK_BYTES = FRAME * STEP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_sched_if #(.ADDR_W(ADDR_W)) bus ();

  fft_frame_sched #(
    .FRAME_SAMPLES(FRAME),
    .ADDR_W       (ADDR_W),
    .ADDR_STEP    (STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: fill count of the writer's bank, FIFO of full banks, busy bank.
  int m_idx, m_wr_bank, m_busy, m_fbank, m_frames, m_stalls, m_starts;
  int m_full[$];
  bit m_allow, m_start, m_ovf, m_derr;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void m_reset();
    m_idx = 0; m_wr_bank = 0; m_busy = -1; m_fbank = 0;
    m_frames = 0; m_stalls = 0; m_full.delete();
    m_allow = 0; m_start = 0; m_ovf = 0; m_derr = 0;
  endfunction

  function automatic bit occupied(input int b);
    if (m_busy == b) return 1'b1;
    foreach (m_full[k]) if (m_full[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit beat, input bit done);
    bit acc;
    acc = beat && m_allow;
    if (en && !m_allow && m_stalls < 65535) m_stalls++;
    if (beat && !m_allow) m_ovf = 1'b1;
    if (done) begin
      if (m_busy >= 0) m_busy = -1;
      else m_derr = 1'b1;
    end
    if (acc) begin
      m_idx++;
      if (m_idx == FRAME) begin
        m_idx = 0;
        m_full.push_back(m_wr_bank);
        m_wr_bank ^= 1;
      end
    end
    m_start = 1'b0;
    if (m_busy < 0 && en && m_full.size() > 0) begin
      m_busy  = m_full.pop_front();
      m_fbank = m_busy;
      m_start = 1'b1;
      m_starts++;
      if (m_frames < 65535) m_frames++;
    end
    m_allow = en && !occupied(m_wr_bank);
  endfunction

  task automatic check_all();
    check("wr_allow", bus.wr_allow, m_allow);
    check("wr_addr", bus.wr_addr, m_wr_bank * BANK_BYTES + m_idx * STEP);
    check("fft_start", bus.fft_start, m_start);
    check("fft_bank", bus.fft_bank, m_fbank);
    check("fft_base", bus.fft_base, m_fbank * BANK_BYTES);
    check("overflow", bus.overflow, m_ovf);
    check("done_err", bus.done_err, m_derr);
`ifdef FFT_SCHED_STATS_EN
    check("frame_cnt", bus.frame_cnt, m_frames);
    check("stall_cnt", bus.stall_cnt, m_stalls);
`endif
  endtask

  // Drive inputs away from the edge, clock once, advance the model, compare.
  task automatic tick(input bit en, input bit beat, input bit done);
    bus.enable = en; bus.wr_beat = beat; bus.fft_done = done;
    @(posedge clk);
    model_step(en, beat, done);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    bus.enable = 0; bus.wr_beat = 0; bus.fft_done = 0;
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          en, beat, done;
    bit          allow;
    int unsigned addr;
    bit          start, derr, ovf;
  } vec_t;

  vec_t tbl[8];
  int   starts_seen;
  bit   allow_min;

  initial begin
    // Short sequence after reset, including fft_done at idle and a rejected beat.
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 1, 1, 0, 0, 1, 0};
    tbl[3] = '{1, 1, 0, 1, 4, 0, 1, 0};
    tbl[4] = '{1, 1, 0, 1, 8, 0, 1, 0};
    tbl[5] = '{0, 0, 0, 0, 8, 0, 1, 0};
    tbl[6] = '{0, 1, 0, 0, 8, 0, 1, 1};
    tbl[7] = '{1, 0, 0, 1, 8, 0, 1, 1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].en, tbl[i].beat, tbl[i].done);
      check($sformatf("tbl%0d_allow", i), bus.wr_allow, tbl[i].allow);
      check($sformatf("tbl%0d_addr", i), bus.wr_addr, tbl[i].addr);
      check($sformatf("tbl%0d_start", i), bus.fft_start, tbl[i].start);
      check($sformatf("tbl%0d_derr", i), bus.done_err, tbl[i].derr);
      check($sformatf("tbl%0d_ovf", i), bus.overflow, tbl[i].ovf);
    end

    // T1: fill bank 0.
    do_reset();
    tick(1, 0, 0);
    check("t1_first_addr", bus.wr_addr, 0);
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 1) check("t1_last_addr", bus.wr_addr, 32'h0FFC);
      tick(1, 1, 0);
    end
    check("t1_start", bus.fft_start, 1);
    check("t1_bank", bus.fft_bank, 0);
    check("t1_base", bus.fft_base, 0);
    check("t1_addr", bus.wr_addr, 32'h1000);

    // T2: fill bank 1, writer then stalls.
    starts_seen = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1, 1, 0);
      if (bus.fft_start) starts_seen++;
    end
    check("t2_no_start", starts_seen, 0);
    check("t2_addr_wrap", bus.wr_addr, 0);
    check("t2_allow_low", bus.wr_allow, 0);
    tick(1, 1, 0);
    check("t2_overflow", bus.overflow, 1);
    check("t2_addr_held", bus.wr_addr, 0);

    // T3: done releases bank 0, bank 1 starts.
    tick(1, 0, 1);
    check("t3_allow", bus.wr_allow, 1);
    check("t3_start", bus.fft_start, 1);
    check("t3_bank", bus.fft_bank, 1);
    check("t3_base", bus.fft_base, 32'h1000);

    // T4: refill bank 0, hand it over, then finish bank 1 coincident with done.
    for (int i = 0; i < FRAME; i++) tick(1, 1, 0);
    check("t4_stall", bus.wr_allow, 0);
    tick(1, 0, 1);
    check("t4_start0", bus.fft_start, 1);
    check("t4_bank0", bus.fft_bank, 0);
    allow_min = 1'b1;
    for (int i = 0; i < FRAME - 1; i++) begin
      tick(1, 1, 0);
      allow_min &= bus.wr_allow;
    end
    tick(1, 1, 1);
    allow_min &= bus.wr_allow;
    check("t4_allow_held", allow_min, 1);
    check("t4_addr", bus.wr_addr, 0);
    check("t4_start1", bus.fft_start, 1);
    check("t4_bank1", bus.fft_bank, 1);

    // T6: asynchronous reset mid-frame.
    for (int i = 0; i < 300; i++) tick(1, 1, 0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("t6_allow", bus.wr_allow, 0);
    check("t6_addr", bus.wr_addr, 0);
    check("t6_start", bus.fft_start, 0);
    check("t6_bank", bus.fft_bank, 0);
    check("t6_base", bus.fft_base, 0);
    check("t6_ovf", bus.overflow, 0);
    check("t6_derr", bus.done_err, 0);
    bus.enable = 0; bus.wr_beat = 0; bus.fft_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 0, 0);
    check("t6_first_addr", bus.wr_addr, 0);
    starts_seen = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      tick(1, 1, 0);
      if (bus.fft_start) starts_seen++;
    end
    check("t6_no_early_start", starts_seen, 0);
    tick(1, 1, 0);
    check("t6_start", bus.fft_start, 1);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      tick($urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 8,
           ($urandom_range(0, 399) == 0) || (m_busy >= 0 && $urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
